// File: rtl/uart_rx_os.sv
// Oversampling UART receiver. It votes a 3-sample majority at each bit centre and
// supports a configurable data width, parity mode and stop-bit count.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for a low sample on an os_tick
// START     | counting to the start-bit centre, then confirming or rejecting it
// DATA      | shifting in DATA_BITS bits, LSB first, one per bit period
// PAR       | sampling the parity bit (only reached when PARITY != 0)
// STOP      | sampling STOP_BITS stop bits; the last sample completes the frame
// WAIT_IDLE | frame error seen; hold off until the line returns high
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx_wire,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BI_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta, rxs;
  logic [2:0]             hist;
  logic [TW-1:0]          tc;
  logic [3:0]             bi;
  logic                   si;
  logic [DATA_BITS-1:0]   sh;
  logic                   par_bit;
  logic                   ferr_pend;
  logic                   any_one;
  logic                   maj, tc_hit, last_stop, par_err;

  assign maj       = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign tc_hit    = os_tick && (tc == ((state_q == START) ? TC_HALF : TC_FULL));
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : si;
  assign par_err   = (PARITY == 1) ? ~(^sh ^ par_bit) :
                     (PARITY == 2) ?  (^sh ^ par_bit) : 1'b0;
  assign rx_busy   = (state_q != IDLE);

  // Next-state logic; every transition happens on an os_tick edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (os_tick && !rxs) state_d = START;
      START:     if (tc_hit) state_d = maj ? IDLE : DATA;
      DATA:      if (tc_hit && bi == BI_LAST) state_d = (PARITY != 0) ? PAR : STOP;
      PAR:       if (tc_hit) state_d = STOP;
      STOP:      if (tc_hit && last_stop) state_d = (ferr_pend | ~maj) ? WAIT_IDLE : IDLE;
      WAIT_IDLE: if (os_tick && rxs) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Synchroniser, majority history, counters, frame assembly and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta       <= 1'b1;
      rxs           <= 1'b1;
      hist          <= 3'b111;
      tc            <= '0;
      bi            <= '0;
      si            <= 1'b0;
      sh            <= '0;
      par_bit       <= 1'b0;
      ferr_pend     <= 1'b0;
      any_one       <= 1'b0;
      rx_data       <= '0;
      rx_data_ready <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      rx_data_ready <= 1'b0;
      rx_meta       <= rx_wire;
      rxs           <= rx_meta;
      if (os_tick) begin
        hist <= {hist[1:0], rxs};
        // tc also restarts at every sample so non-power-of-two OVERSAMPLE works.
        tc   <= (state_d != state_q || tc_hit) ? '0 : tc + TW'(1);
        case (state_q)
          IDLE: begin
            bi        <= '0;
            si        <= 1'b0;
            ferr_pend <= 1'b0;
            any_one   <= 1'b0;
          end
          DATA: if (tc_hit) begin
            sh      <= {maj, sh[DATA_BITS-1:1]};
            bi      <= bi + 4'd1;
            any_one <= any_one | maj;
          end
          PAR: if (tc_hit) begin
            par_bit <= maj;
            any_one <= any_one | maj;
          end
          STOP: if (tc_hit) begin
            si      <= si + 1'b1;
            any_one <= any_one | maj;
            if (!maj) ferr_pend <= 1'b1;
            if (last_stop) begin
              rx_data       <= sh;
              rx_parity_err <= par_err;
              rx_frame_err  <= ferr_pend | ~maj;
              rx_break      <= ~(any_one | maj);
              rx_data_ready <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three instances (8N1, 7E1, 8N2) share clock,
// reset and os_tick; each has its own serial line.
module tb_uart_rx_os;

  logic clk = 1'b0;
  logic rst;
  logic os_tick = 1'b0;
  logic tick_ph = 1'b0;
  logic rx_a, rx_b, rx_c;

  logic [7:0] data_a, data_c;
  logic [6:0] data_b;
  logic rdy_a, pe_a, fe_a, brk_a, busy_a;
  logic rdy_b, pe_b, fe_b, brk_b, busy_b;
  logic rdy_c, pe_c, fe_c, brk_c, busy_c;

  int checks = 0;
  int failures = 0;
  int n_a = 0, n_b = 0, n_c = 0;
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];
  logic [10:0] q_c[$];

  uart_rx_os dut_a (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx_wire(rx_a),
    .rx_data(data_a), .rx_data_ready(rdy_a), .rx_parity_err(pe_a),
    .rx_frame_err(fe_a), .rx_break(brk_a), .rx_busy(busy_a)
  );

  uart_rx_os #(.DATA_BITS(7), .PARITY(2)) dut_b (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx_wire(rx_b),
    .rx_data(data_b), .rx_data_ready(rdy_b), .rx_parity_err(pe_b),
    .rx_frame_err(fe_b), .rx_break(brk_b), .rx_busy(busy_b)
  );

  uart_rx_os #(.STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx_wire(rx_c),
    .rx_data(data_c), .rx_data_ready(rdy_c), .rx_parity_err(pe_c),
    .rx_frame_err(fe_c), .rx_break(brk_c), .rx_busy(busy_c)
  );

  always #5 clk = ~clk;

  // os_tick is high for one clk out of every two; changed on the falling edge.
  always @(negedge clk) begin
    tick_ph = ~tick_ph;
    os_tick = tick_ph;
  end

  // Record every completed frame as {break, frame_err, parity_err, data}.
  always @(negedge clk) begin
    if (rdy_a) begin n_a++; q_a.push_back({brk_a, fe_a, pe_a, data_a}); end
    if (rdy_b) begin n_b++; q_b.push_back({brk_b, fe_b, pe_b, 1'b0, data_b}); end
    if (rdy_c) begin n_c++; q_c.push_back({brk_c, fe_c, pe_c, data_c}); end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(sel, bits[i]);
      wait_ticks(16);
    end
    set_line(sel, 1'b1);
  endtask

  task automatic test_reset;
    if ({data_a, rdy_a, pe_a, fe_a, brk_a, busy_a} !== 13'h0) begin
      failures++; $display("FAIL reset_a got=%h want=0", {data_a, rdy_a, pe_a, fe_a, brk_a, busy_a});
    end
    checks++;
    if ({data_b, rdy_b, pe_b, fe_b, brk_b, busy_b} !== 12'h0) begin
      failures++; $display("FAIL reset_b got=%h want=0", {data_b, rdy_b, pe_b, fe_b, brk_b, busy_b});
    end
    checks++;
    if ({data_c, rdy_c, pe_c, fe_c, brk_c, busy_c} !== 13'h0) begin
      failures++; $display("FAIL reset_c got=%h want=0", {data_c, rdy_c, pe_c, fe_c, brk_c, busy_c});
    end
    checks++;
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = n_a;
    send(0, {6'h3f, 1'b1, 8'h55, 1'b0}, 10);
    send(0, {6'h3f, 1'b1, 8'hA3, 1'b0}, 10);
    wait_ticks(4);
    checks++;
    if (n_a != n0 + 2) begin
      failures++; $display("FAIL b2b_count got=%0d want=%0d", n_a - n0, 2);
    end else begin
      checks++;
      if (q_a[n0] !== {3'b000, 8'h55}) begin
        failures++; $display("FAIL b2b_first got=%h want=%h", q_a[n0], {3'b000, 8'h55});
      end
      checks++;
      if (q_a[n0+1] !== {3'b000, 8'hA3}) begin
        failures++; $display("FAIL b2b_second got=%h want=%h", q_a[n0+1], {3'b000, 8'hA3});
      end
    end
    checks++;
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL b2b_busy got=%b want=0", busy_a);
    end
  endtask

  task automatic test_parity;
    int n0;
    n0 = n_b;
    send(1, {6'h3f, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
    wait_ticks(4);
    send(1, {6'h3f, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
    wait_ticks(4);
    checks++;
    if (n_b != n0 + 2) begin
      failures++; $display("FAIL parity_count got=%0d want=%0d", n_b - n0, 2);
    end else begin
      checks++;
      if (q_b[n0] !== {3'b000, 8'h41}) begin
        failures++; $display("FAIL parity_good got=%h want=%h", q_b[n0], {3'b000, 8'h41});
      end
      checks++;
      if (q_b[n0+1] !== {3'b001, 8'h41}) begin
        failures++; $display("FAIL parity_bad got=%h want=%h", q_b[n0+1], {3'b001, 8'h41});
      end
    end
  endtask

  task automatic test_glitch;
    int n0;
    logic seen_busy;
    n0 = n_a;
    seen_busy = 1'b0;
    rx_a = 1'b0;
    wait_ticks(3);
    rx_a = 1'b1;
    for (int i = 0; i < 24; i++) begin
      wait_ticks(1);
      if (busy_a) seen_busy = 1'b1;
    end
    checks++;
    if (seen_busy !== 1'b1) begin
      failures++; $display("FAIL false_start_busy_seen got=%b want=1", seen_busy);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL false_start_busy got=%b want=0", busy_a);
    end
    checks++;
    if (n_a != n0) begin
      failures++; $display("FAIL false_start_ready got=%0d want=0", n_a - n0);
    end
    // 0x00 with a one-tick high flip at the centre of data bit 3
    n0 = n_a;
    rx_a = 1'b0;
    wait_ticks(16 * 4 + 7);
    rx_a = 1'b1;
    wait_ticks(1);
    rx_a = 1'b0;
    wait_ticks(8 + 16 * 4);
    rx_a = 1'b1;
    wait_ticks(20);
    checks++;
    if (n_a != n0 + 1) begin
      failures++; $display("FAIL glitch_count got=%0d want=1", n_a - n0);
    end else begin
      checks++;
      if (q_a[n0] !== 11'h000) begin
        failures++; $display("FAIL glitch_data got=%h want=%h", q_a[n0], 11'h000);
      end
    end
  endtask

  task automatic test_two_stop;
    int n0;
    n0 = n_c;
    send(2, {5'h1f, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    wait_ticks(4);
    checks++;
    if (n_c != n0 + 1) begin
      failures++; $display("FAIL stop2_count got=%0d want=1", n_c - n0);
    end else begin
      checks++;
      if (q_c[n0] !== {3'b010, 8'h3C}) begin
        failures++; $display("FAIL stop2_frame got=%h want=%h", q_c[n0], {3'b010, 8'h3C});
      end
    end
    checks++;
    if (busy_c !== 1'b0) begin
      failures++; $display("FAIL stop2_busy got=%b want=0", busy_c);
    end
  endtask

  task automatic test_break;
    int n0;
    n0 = n_a;
    rx_a = 1'b0;
    wait_ticks(3 * 160);
    checks++;
    if (n_a != n0 + 1) begin
      failures++; $display("FAIL break_count got=%0d want=1", n_a - n0);
    end else begin
      checks++;
      if (q_a[n0] !== {3'b110, 8'h00}) begin
        failures++; $display("FAIL break_frame got=%h want=%h", q_a[n0], {3'b110, 8'h00});
      end
    end
    checks++;
    if (busy_a !== 1'b1) begin
      failures++; $display("FAIL break_hold_busy got=%b want=1", busy_a);
    end
    rx_a = 1'b1;
    wait_ticks(20);
    checks++;
    if (busy_a !== 1'b0 || n_a != n0 + 1) begin
      failures++; $display("FAIL break_release got busy=%b count=%0d want busy=0 count=1", busy_a, n_a - n0);
    end
    send(0, {6'h3f, 1'b1, 8'h12, 1'b0}, 10);
    wait_ticks(4);
    checks++;
    if (n_a != n0 + 2) begin
      failures++; $display("FAIL after_break_count got=%0d want=2", n_a - n0);
    end else begin
      checks++;
      if (q_a[n0+1] !== {3'b000, 8'h12}) begin
        failures++; $display("FAIL after_break_frame got=%h want=%h", q_a[n0+1], {3'b000, 8'h12});
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int n0;
    n0 = n_a;
    rx_a = 1'b0;
    wait_ticks(16 * 5);
    rx_a = 1'b1;
    wait_ticks(8);
    checks++;
    if (busy_a !== 1'b1) begin
      failures++; $display("FAIL midframe_busy got=%b want=1", busy_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({data_a, rdy_a, pe_a, fe_a, brk_a, busy_a} !== 13'h0) begin
      failures++; $display("FAIL async_reset got=%h want=0", {data_a, rdy_a, pe_a, fe_a, brk_a, busy_a});
    end
    wait_ticks(4);
    rst = 1'b0;
    wait_ticks(10);
    checks++;
    if (n_a != n0) begin
      failures++; $display("FAIL reset_no_ready got=%0d want=0", n_a - n0);
    end
    send(0, {6'h3f, 1'b1, 8'h0F, 1'b0}, 10);
    wait_ticks(4);
    checks++;
    if (n_a != n0 + 1) begin
      failures++; $display("FAIL post_reset_count got=%0d want=1", n_a - n0);
    end else begin
      checks++;
      if (q_a[n0] !== {3'b000, 8'h0F}) begin
        failures++; $display("FAIL post_reset_frame got=%h want=%h", q_a[n0], {3'b000, 8'h0F});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    #22;
    test_reset;
    rst = 1'b0;
    wait_ticks(8);
    test_back_to_back;
    test_parity;
    test_glitch;
    test_two_stop;
    test_break;
    test_reset_mid_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised UART receiver that samples the serial line at OVERSAMPLE× the baud rate and takes a 3-sample majority vote at each bit centre. It supports configurable data width, parity mode and stop-bit count, and reports parity, framing and break conditions. It sits downstream of baud_generator, whose tick is configured to the oversample rate, and is the successor to the fixed-format 8N1 receiver.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first
OVERSAMPLE, 16, os_tick pulses per bit period; even, >= 8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked; 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
os_tick  input  1  single-clk strobe at OVERSAMPLE × baud
rx_wire  input  1  asynchronous serial line; idles high
rx_data  output  DATA_BITS  last received word; held until next frame completes
rx_data_ready  output  1  one-clk pulse when a frame completes
rx_parity_err  output  1  parity mismatch on last frame; held
rx_frame_err  output  1  stop bit sampled low on last frame; held
rx_break  output  1  last frame was all-zero including stop bit(s); held
rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, any time including mid-frame): state IDLE, counters 0, all outputs 0, synchroniser flops and majority history preset to 1.
- rx_wire passes through a 2-FF synchroniser (rxs). All sampling uses rxs and happens only on clk edges where os_tick = 1.
- Majority history: a 3-bit shift register of rxs, shifted on every os_tick. The bit value is the majority of its 3 bits.
- Tick counter tc is log2(OVERSAMPLE) bits wide. It resets to 0 on every state entry and increments on each os_tick.
- IDLE: on an os_tick with rxs = 0, go to START.
- START: when tc reaches OVERSAMPLE/2 − 1 (bit centre):
  - majority = 1 → false start, return to IDLE with no outputs changed;
  - majority = 0 → go to DATA with the bit index at 0.
- DATA: every OVERSAMPLE ticks, shift the majority into the MSB of the shift register (LSB-first reception). After DATA_BITS bits, go to PARITY if PARITY ≠ 0, otherwise to STOP.
- PARITY: after OVERSAMPLE ticks, sample one bit. Error if the XOR of the data bits and the parity bit is 0 for odd, or 1 for even.
- STOP: sample STOP_BITS bits, each OVERSAMPLE ticks apart. Any low sample sets the pending frame error.
- Completion is on the clk edge of the last stop-bit sample:
  - rx_data is loaded;
  - rx_parity_err, rx_frame_err and rx_break are updated together;
  - rx_data_ready = 1 for exactly that one cycle.
  - Next state is IDLE if there was no frame error, otherwise WAIT_IDLE.
- rx_break = 1 iff all data bits, the parity bit (if present) and all stop bits are 0. rx_frame_err is also 1 in this case.
- WAIT_IDLE: stay until an os_tick with rxs = 1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Latency: the rx_wire start edge reaches rxs 2 clks later. rx_data_ready fires (1 + DATA_BITS + P + STOP_BITS) × OVERSAMPLE − OVERSAMPLE/2 os_ticks (±1) after IDLE detects the start, where P = 1 if PARITY ≠ 0.
- Back-to-back frames: a new start edge is accepted on the first os_tick after returning to IDLE. There is no idle gap requirement beyond the stop bit(s).
- When os_tick = 0, all state, counters and history hold.
- A single-sample glitch at a bit centre is rejected by the majority vote.

Test Plan:
- Defaults (8N1, OS=16): send 0x55 then 0xA3 back to back → two ready pulses; rx_data = 0x55 then 0xA3; all error flags 0.
- PARITY=2, DATA_BITS=7: send 0x41 with correct parity bit 0 → rx_parity_err = 0; resend with parity bit 1 → rx_data = 0x41, rx_parity_err = 1.
- Glitches: a 3-os_tick-wide low pulse on an idle line → false start, no ready pulse, rx_busy returns to 0. A 1-os_tick flip at the centre of data bit 3 of 0x00 → rx_data = 0x00.
- STOP_BITS=2: send 0x3C with the second stop bit low → rx_frame_err = 1, rx_break = 0, rx_data = 0x3C.
- Break: hold rx_wire low for 3 frame times → exactly one ready pulse with rx_data = 0, rx_frame_err = 1, rx_break = 1. No further pulses until the line is high; a following 0x12 is received cleanly with flags cleared.
- Reset: assert rst during data bit 4 of 0xF0 → all outputs 0 asynchronously, no ready pulse. After release, a 0x0F frame is received correctly.
